// File: rtl/decoder_3x8_pulse_pkg.sv
// rtl/decoder_3x8_pulse_pkg.sv - shared state encodings and widths for the 3-to-8 pulse decoder
package decoder_pkg;

  localparam int DEC_W = 3;
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_3x8_pulse_if.sv
// rtl/decoder_3x8_pulse_if.sv - code handshake and one-hot output bundle
// Optional parity pins exist only when DEC_PARITY_EN is defined.
interface decoder_3x8_pulse_if;
  import decoder_pkg::*;

  logic             enable;
  logic [DEC_W-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] data_out;
  logic             out_valid;
  logic             busy;
`ifdef DEC_PARITY_EN
  logic             data_par;
  logic             par_err;

  modport master (
    output enable, data_in, in_valid, data_par,
    input  in_ready, data_out, out_valid, busy, par_err
  );
  modport slave (
    input  enable, data_in, in_valid, data_par,
    output in_ready, data_out, out_valid, busy, par_err
  );
`else
  modport master (
    output enable, data_in, in_valid,
    input  in_ready, data_out, out_valid, busy
  );
  modport slave (
    input  enable, data_in, in_valid,
    output in_ready, data_out, out_valid, busy
  );
`endif

endinterface

// File: rtl/decoder_3x8_pulse_hold_counter.sv
// rtl/decoder_3x8_pulse_hold_counter.sv - loadable down-counter with zero flag
module hold_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (load_i)
      count_d = load_val_i;
    else if (dec_i && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/decoder_3x8_pulse.sv
// rtl/decoder_3x8_pulse.sv - handshaked 3-to-8 decoder holding a one-hot pulse, then one gap cycle
// DEC_PARITY_EN adds even-parity checking of the incoming code.
module decoder_3x8_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder_3x8_pulse_if.slave  bus
);

  // A hold of zero would never leave DRIVE cleanly, so it degrades to one cycle.
  localparam int               HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_EFF - 1);

  state_e           state_q;
  logic [OUT_W-1:0] data_out_q;
  logic             accept;
  logic             code_ok;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_clr;

  assign bus.in_ready = (state_q == ST_IDLE) && bus.enable;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef DEC_PARITY_EN
  logic par_err_q;

  assign code_ok = ((^bus.data_in) == bus.data_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_err_q <= 1'b0;
    else
      par_err_q <= accept && !code_ok;
  end

  assign bus.par_err = par_err_q;
`else
  assign code_ok = 1'b1;
`endif

  assign cnt_load = accept && code_ok;
  assign cnt_dec  = (state_q == ST_DRIVE) && bus.enable;
  assign cnt_clr  = (state_q == ST_DRIVE) && !bus.enable;

  hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Abort on enable low is checked before the hold expiry so it always skips GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && code_ok) begin
            data_out_q <= OUT_W'(1) << bus.data_in;
            state_q    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (!bus.enable) begin
            data_out_q <= '0;
            state_q    <= ST_IDLE;
          end else if (cnt_zero) begin
            data_out_q <= '0;
            state_q    <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          data_out_q <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = |data_out_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// tb/tb_decoder_3x8_pulse.sv - directed self-checking bench for decoder_3x8_pulse (DEC_PARITY_EN optional)
module tb_decoder_3x8_pulse;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  decoder_3x8_pulse_if bus ();
  decoder_3x8_pulse_if bus0 ();

  decoder_3x8_pulse #(.HOLD_CYCLES(4), .CNT_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  decoder_3x8_pulse #(.HOLD_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input logic [2:0] code);
    bus.data_in  = code;
    bus.in_valid = 1'b1;
`ifdef DEC_PARITY_EN
    bus.data_par = ^code;
`endif
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    #1;
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    #3 rst_n = 1'b1;
    tick();
    set_code(3'd5);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.data_out !== 8'h20) begin n_fail++; $display("FAIL pre_reset_drive: got %h want 20", bus.data_out); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL midreset_data_out: got %h want 00", bus.data_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
    #2 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL post_reset_idle: got %h want 00", bus.data_out); end
  endtask

  task automatic test_basic();
    bus.enable = 1'b1;
    set_code(3'd3);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_pre: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.data_out !== 8'h08) begin n_fail++; $display("FAIL basic_accept: got %h want 08", bus.data_out); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drive: got %b want 0", bus.in_ready); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_checks++; if (bus.data_out !== 8'h08) begin n_fail++; $display("FAIL basic_hold%0d: got %h want 08", i, bus.data_out); end
    end
    tick();
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL basic_gap_data: got %h want 00", bus.data_out); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_gap_busy: got %b want 1", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_gap_ready: got %b want 0", bus.in_ready); end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int           accepts;
    logic [7:0]   exp;
    accepts = 0;
    bus.enable = 1'b1;
    for (int c = 0; c < 48; c++) begin
      set_code(3'(c / 6));
      @(negedge clk);
      if (bus.in_ready && bus.in_valid) accepts++;
      tick();
      exp = ((c % 6) < 4) ? (8'h01 << (c / 6)) : 8'h00;
      n_checks++; if (bus.data_out !== exp) begin n_fail++; $display("FAIL sweep_c%0d: got %h want %h", c, bus.data_out, exp); end
      if ($countones(bus.data_out) > 1) begin n_fail++; $display("FAIL sweep_onehot_c%0d: got %h", c, bus.data_out); end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (accepts !== 8) begin n_fail++; $display("FAIL sweep_accepts: got %0d want 8", accepts); end
  endtask

  task automatic test_abort();
    bus.enable = 1'b1;
    set_code(3'd7);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.data_out !== 8'h80) begin n_fail++; $display("FAIL abort_accept: got %h want 80", bus.data_out); end
    tick();
    bus.enable = 1'b0;
    tick();
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL abort_data: got %h want 00", bus.data_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_gap: got %b want 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", bus.in_ready); end
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL abort_no_redrive%0d: got %h want 00", i, bus.data_out); end
    end
  endtask

  task automatic test_abort_vs_zero();
    bus.enable = 1'b1;
    set_code(3'd2);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (bus.data_out !== 8'h04) begin n_fail++; $display("FAIL az_last_hold: got %h want 04", bus.data_out); end
    bus.enable = 1'b0;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL az_abort_wins: got %b want 0", bus.busy); end
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL az_data: got %h want 00", bus.data_out); end
  endtask

  task automatic test_enable_low_idle();
    bus.enable = 1'b0;
    set_code(3'd4);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_ready: got %b want 0", bus.in_ready); end
    tick();
    tick();
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL en_low_data: got %h want 00", bus.data_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL en_low_busy: got %b want 0", bus.busy); end
    bus.in_valid = 1'b0;
    bus.enable   = 1'b1;
    tick();
  endtask

  task automatic test_gap_ignore();
    bus.enable = 1'b1;
    set_code(3'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    n_checks++; if (bus.busy !== 1'b1 || bus.data_out !== 8'h00) begin n_fail++; $display("FAIL gap_state: got busy %b data %h want 1 00", bus.busy, bus.data_out); end
    set_code(3'd5);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL gap_ready: got %b want 0", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.data_out !== 8'h00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL gap_ignored%0d: got data %h busy %b want 00 0", i, bus.data_out, bus.busy); end
      tick();
    end
  endtask

  task automatic test_hold_zero();
    bus0.enable   = 1'b1;
    bus0.data_in  = 3'd1;
    bus0.in_valid = 1'b1;
`ifdef DEC_PARITY_EN
    bus0.data_par = 1'b1;
`endif
    tick();
    bus0.in_valid = 1'b0;
    n_checks++; if (bus0.data_out !== 8'h02) begin n_fail++; $display("FAIL h0_pulse: got %h want 02", bus0.data_out); end
    tick();
    n_checks++; if (bus0.data_out !== 8'h00 || bus0.busy !== 1'b1) begin n_fail++; $display("FAIL h0_gap: got data %h busy %b want 00 1", bus0.data_out, bus0.busy); end
    tick();
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL h0_idle: got %b want 0", bus0.busy); end
  endtask

`ifdef DEC_PARITY_EN
  task automatic test_parity();
    bus.enable   = 1'b1;
    bus.data_in  = 3'd6;
    bus.in_valid = 1'b1;
    bus.data_par = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.par_err !== 1'b1) begin n_fail++; $display("FAIL par_err_pulse: got %b want 1", bus.par_err); end
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL par_bad_data: got %h want 00", bus.data_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL par_bad_idle: got %b want 0", bus.busy); end
    tick();
    n_checks++; if (bus.par_err !== 1'b0) begin n_fail++; $display("FAIL par_err_clear: got %b want 0", bus.par_err); end
    bus.in_valid = 1'b1;
    bus.data_par = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.data_out !== 8'h40) begin n_fail++; $display("FAIL par_good_data: got %h want 40", bus.data_out); end
    n_checks++; if (bus.par_err !== 1'b0) begin n_fail++; $display("FAIL par_good_err: got %b want 0", bus.par_err); end
    for (int i = 0; i < 6; i++) tick();
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.data_in   = 3'd0;
    bus.in_valid  = 1'b0;
    bus0.enable   = 1'b0;
    bus0.data_in  = 3'd0;
    bus0.in_valid = 1'b0;
`ifdef DEC_PARITY_EN
    bus.data_par  = 1'b0;
    bus0.data_par = 1'b0;
`endif
    #8;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_abort_vs_zero();
    test_enable_low_idle();
    test_gap_ignore();
    test_hold_zero();
`ifdef DEC_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
